// File: rtl/alu_pkg.sv
// Shared ALU definitions: select encodings, R-type funct codes and the
// decoded-entry record passed from decode/issue into execute.
package alu_pkg;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_SLT = 3'b100;
  localparam logic [2:0] SEL_MUL = 3'b110;
  localparam logic [2:0] SEL_NOP = 3'b111;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MUL  = 6'b011000;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  // Idle value an empty slot holds: zero operands, NOP select, no destination.
  function automatic entry_t idle_entry();
    entry_t e;
    e.op1     = '0;
    e.op2     = '0;
    e.sel     = SEL_NOP;
    e.rd      = '0;
    e.illegal = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/r_type_decoder.sv
// Combinational R-type decoder: instruction word to ALU select, destination
// register and an illegal flag. Only the all-zero word is treated as NOP.
module r_type_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  sel,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    sel     = SEL_NOP;
    rd      = '0;
    illegal = 1'b0;
    if (instr == 32'd0) begin
      sel = SEL_NOP;
    end else if (opcode != OPC_RTYPE) begin
      illegal = 1'b1;
    end else begin
      rd = instr[15:11];
      case (funct)
        FUNCT_ADD: sel = SEL_ADD;
        FUNCT_SUB: sel = SEL_SUB;
        FUNCT_AND: sel = SEL_AND;
        FUNCT_OR:  sel = SEL_OR;
        FUNCT_SLT: sel = SEL_SLT;
        FUNCT_MUL: sel = SEL_MUL;
        default: begin
          sel     = SEL_NOP;
          rd      = '0;
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: decodes R-type instructions, resolves operands with
// write-back forwarding, and presents them to the ALU through a 2-entry skid buffer.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_fwd_valid,
  input  logic [4:0]  i_fwd_rd,
  input  logic [31:0] i_fwd_data,
  input  logic        i_flush,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [2:0]  o_sel,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0] count;
  logic [1:0] next_count;
  logic       ready_q;
  entry_t     head;
  entry_t     tail;
  entry_t     new_entry;
  logic       push;
  logic       pop;

  logic [2:0] dec_sel;
  logic [4:0] dec_rd;
  logic       dec_illegal;

  r_type_decoder u_decoder (
    .instr   (i_instr),
    .sel     (dec_sel),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  // $0 always reads zero, and a write-back to $0 must never be forwarded.
  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf_data,
                                          input logic fwd_valid, input logic [4:0] fwd_rd,
                                          input logic [31:0] fwd_data);
    if (idx == 5'd0)
      return 32'd0;
    else if (fwd_valid && fwd_rd == idx)
      return fwd_data;
    else
      return rf_data;
  endfunction

  always_comb begin
    new_entry         = idle_entry();
    new_entry.sel     = dec_sel;
    new_entry.rd      = dec_rd;
    new_entry.illegal = dec_illegal;
    if (!dec_illegal) begin
      new_entry.op1 = resolve(i_instr[25:21], i_rs_data, i_fwd_valid, i_fwd_rd, i_fwd_data);
      new_entry.op2 = resolve(i_instr[20:16], i_rt_data, i_fwd_valid, i_fwd_rd, i_fwd_data);
    end
  end

  assign push = i_valid && ready_q && !i_flush;
  assign pop  = (count != 2'd0) && i_ready;

  always_comb begin
    if (i_flush)
      next_count = 2'd0;
    else
      next_count = count + {1'b0, push} - {1'b0, pop};
  end

  // Head is the ALU-facing slot; tail only fills while the head is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count   <= 2'd0;
      ready_q <= 1'b1;
      head    <= idle_entry();
      tail    <= idle_entry();
    end else begin
      count   <= next_count;
      ready_q <= (next_count < FULL);
      if (!i_flush) begin
        if (pop) begin
          if (count == 2'd2) begin
            head <= tail;
            if (push) tail <= new_entry;
          end else if (push) begin
            head <= new_entry;
          end
        end else if (push) begin
          if (count == 2'd0)
            head <= new_entry;
          else
            tail <= new_entry;
        end
      end
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = (count != 2'd0);
  assign o_op1     = head.op1;
  assign o_op2     = head.op2;
  assign o_sel     = head.sel;
  assign o_rd      = head.rd;
  assign o_illegal = head.illegal;

endmodule
